// File: rtl/point_stream_fifo.sv
// UART byte stream to point FIFO: hunts for a run of zero bytes, assembles big-endian
// 32-bit point words, and buffers them in a first-word-fall-through FIFO on a valid/ready port.
module point_stream_fifo #(
  parameter int          SYNC_LEN   = 8,
  parameter logic [31:0] END_WORD   = 32'h01010101,
  parameter int          MAX_PTS    = 20000,
  parameter int          DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  output logic                  pt_valid,
  input  logic                  pt_ready,
  output logic [11:0]           pt_x,
  output logic [11:0]           pt_y,
  output logic                  pt_draw,
  output logic                  frame_active,
  output logic                  frame_done,
  output logic                  frame_abort,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   fifo_level
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0]          SYNC_LAST = 4'(SYNC_LEN - 1);
  localparam logic [14:0]         MAX_CNT   = 15'(MAX_PTS);
  localparam logic [DEPTH_LOG2:0] FULL_LVL  = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic {HUNT, RECV} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              zero_cnt_q, zero_cnt_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [23:0]             word_q, word_d;
  logic [14:0]             pt_cnt_q, pt_cnt_d;
  logic                    overflow_q, overflow_d;
  logic                    done_q, done_d;
  logic                    abort_q, abort_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     level_q, level_d;
  logic [24:0]             mem_q [DEPTH];

  logic [31:0] full_word;
  logic        push_req, push, pop;

  assign full_word = {word_q, rx_byte};
  assign pop       = (level_q != '0) && pt_ready;

  always_comb begin
    state_d    = state_q;
    zero_cnt_d = zero_cnt_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    pt_cnt_d   = pt_cnt_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    push_req   = 1'b0;
    case (state_q)
      HUNT: begin
        if (rx_valid) begin
          if (rx_byte == 8'h00) begin
            if (zero_cnt_q == SYNC_LAST) begin
              state_d    = RECV;
              zero_cnt_d = '0;
              byte_idx_d = '0;
              pt_cnt_d   = '0;
              overflow_d = 1'b0;
            end else begin
              zero_cnt_d = zero_cnt_q + 4'd1;
            end
          end else begin
            zero_cnt_d = '0;
          end
        end
      end
      RECV: begin
        if (rx_valid) begin
          word_d     = full_word[23:0];
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            if (full_word == END_WORD) begin
              done_d  = 1'b1;
              state_d = HUNT;
            end else begin
              push_req = 1'b1;
              pt_cnt_d = pt_cnt_q + 15'd1;
              // The point that hits the limit is still written.
              if (pt_cnt_d == MAX_CNT) begin
                abort_d = 1'b1;
                state_d = HUNT;
              end
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase

    // A full FIFO still takes the word when the head leaves in the same cycle.
    push = push_req && ((level_q != FULL_LVL) || pop);
    if (push_req && !push) overflow_d = 1'b1;

    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(push);
    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop);
    level_d  = level_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HUNT;
      zero_cnt_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      pt_cnt_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      zero_cnt_q <= zero_cnt_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      pt_cnt_q   <= pt_cnt_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= full_word[24:0];
  end

  assign pt_valid                 = (level_q != '0);
  assign {pt_draw, pt_x, pt_y}    = pt_valid ? mem_q[rd_ptr_q] : 25'd0;
  assign frame_active             = (state_q == RECV);
  assign frame_done               = done_q;
  assign frame_abort              = abort_q;
  assign overflow                 = overflow_q;
  assign fifo_level               = level_q;

endmodule

// File: tb/tb_point_stream_fifo.sv
// Bench for point_stream_fifo: table-driven basic frame, directed corner sequences, and
// randomized frames checked every cycle against a queue-based reference model.
module tb_point_stream_fifo;

  localparam int          SYNC_LEN   = 8;
  localparam logic [31:0] END_WORD   = 32'h01010101;
  localparam int          MAX_PTS    = 70;
  localparam int          DEPTH_LOG2 = 6;
  localparam int          DEPTH      = 1 << DEPTH_LOG2;

  logic clk = 1'b0;
  logic reset, rx_valid, pt_ready;
  logic [7:0] rx_byte;
  logic pt_valid, pt_draw, frame_active, frame_done, frame_abort, overflow;
  logic [11:0] pt_x, pt_y;
  logic [DEPTH_LOG2:0] fifo_level;

  always #5 clk = ~clk;

  point_stream_fifo #(.SYNC_LEN(SYNC_LEN), .END_WORD(END_WORD), .MAX_PTS(MAX_PTS),
                      .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y), .pt_draw(pt_draw),
    .frame_active(frame_active), .frame_done(frame_done), .frame_abort(frame_abort),
    .overflow(overflow), .fifo_level(fifo_level));

  int n_pass = 0, n_total = 0, hs_cnt = 0;

  // Reference model state: frame flag, zero run, collected bytes, FIFO as a queue.
  logic [24:0] m_fifo[$];
  bit          m_recv, m_ovf, m_done, m_abort;
  int          m_zeros, m_nbytes, m_pts;
  logic [31:0] m_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_step(input logic r, input logic v, input logic [7:0] b, input logic rdy);
    if (r) begin
      m_fifo.delete(); m_recv = 0; m_ovf = 0; m_done = 0; m_abort = 0;
      m_zeros = 0; m_nbytes = 0; m_pts = 0; m_word = 0;
      return;
    end
    m_done = 0; m_abort = 0;
    if (m_fifo.size() > 0 && rdy) void'(m_fifo.pop_front());
    if (!v) return;
    if (!m_recv) begin
      if (b == 8'h00) begin
        m_zeros++;
        if (m_zeros == SYNC_LEN) begin
          m_recv = 1; m_zeros = 0; m_nbytes = 0; m_pts = 0; m_ovf = 0;
        end
      end else m_zeros = 0;
    end else begin
      m_word = (m_word << 8) | 32'(b);
      m_nbytes++;
      if (m_nbytes == 4) begin
        m_nbytes = 0;
        if (m_word == END_WORD) begin
          m_done = 1; m_recv = 0;
        end else begin
          if (m_fifo.size() < DEPTH) m_fifo.push_back(m_word[24:0]);
          else m_ovf = 1;
          m_pts++;
          if (m_pts == MAX_PTS) begin m_abort = 1; m_recv = 0; end
        end
      end
    end
  endtask

  task automatic check_model();
    logic [24:0] head;
    head = (m_fifo.size() > 0) ? m_fifo[0] : 25'd0;
    chk("m_valid", 32'(pt_valid), 32'(m_fifo.size() > 0));
    chk("m_head", {7'd0, pt_draw, pt_x, pt_y}, {7'd0, head});
    chk("m_level", 32'(fifo_level), 32'(m_fifo.size()));
    chk("m_active", 32'(frame_active), 32'(m_recv));
    chk("m_done", 32'(frame_done), 32'(m_done));
    chk("m_abort", 32'(frame_abort), 32'(m_abort));
    chk("m_ovf", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic cyc(input logic r, input logic v, input logic [7:0] b, input logic rdy);
    reset = r; rx_valid = v; rx_byte = b; pt_ready = rdy;
    #1;
    if (!r && pt_valid && pt_ready) hs_cnt++;
    @(posedge clk);
    model_step(r, v, b, rdy);
    #1;
    check_model();
  endtask

  task automatic send_sync(input logic rdy);
    for (int i = 0; i < SYNC_LEN; i++) cyc(0, 1, 8'h00, rdy);
  endtask

  task automatic send_word(input logic [31:0] w, input logic rdy);
    for (int i = 3; i >= 0; i--) cyc(0, 1, w[8*i +: 8], rdy);
  endtask

  function automatic logic [31:0] pt_word(input int i);
    logic [11:0] x, y;
    x = 12'(i + 'h200);
    y = ~12'(i);
    return {7'd0, 1'(i & 1), x, y};
  endfunction

  typedef struct {
    logic v; logic [7:0] b; logic rdy;
    logic e_valid; logic [11:0] e_x, e_y; logic e_draw; logic e_act, e_done;
    logic [DEPTH_LOG2:0] e_lvl;
  } vec_t;
  vec_t tv[17];

  initial begin
    reset = 1; rx_valid = 0; rx_byte = 0; pt_ready = 0;

    // Reset state
    cyc(1, 0, 0, 0);
    cyc(1, 1, 8'h00, 1);
    chk("rst_valid", 32'(pt_valid), 0);
    chk("rst_xy", {7'd0, pt_draw, pt_x, pt_y}, 0);
    chk("rst_flags", {frame_active, frame_done, frame_abort, overflow}, 0);
    chk("rst_level", 32'(fifo_level), 0);

    // Basic frame: one point then END_WORD
    for (int i = 0; i < 7; i++) tv[i] = '{1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[7]  = '{1, 8'h00, 0, 0, 12'h0, 12'h0, 0, 1, 0, 0};
    tv[8]  = '{1, 8'h00, 0, 0, 12'h0, 12'h0, 0, 1, 0, 0};
    tv[9]  = '{1, 8'h12, 0, 0, 12'h0, 12'h0, 0, 1, 0, 0};
    tv[10] = '{1, 8'h34, 0, 0, 12'h0, 12'h0, 0, 1, 0, 0};
    tv[11] = '{1, 8'h56, 0, 1, 12'h123, 12'h456, 0, 1, 0, 1};
    for (int i = 12; i < 15; i++) tv[i] = '{1, 8'h01, 0, 1, 12'h123, 12'h456, 0, 1, 0, 1};
    tv[15] = '{1, 8'h01, 0, 1, 12'h123, 12'h456, 0, 0, 1, 1};
    tv[16] = '{0, 8'h00, 1, 0, 12'h0, 12'h0, 0, 0, 0, 0};
    for (int i = 0; i < 17; i++) begin
      cyc(0, tv[i].v, tv[i].b, tv[i].rdy);
      chk($sformatf("tv%0d_valid", i), 32'(pt_valid), 32'(tv[i].e_valid));
      chk($sformatf("tv%0d_pt", i), {7'd0, pt_draw, pt_x, pt_y},
          {7'd0, tv[i].e_draw, tv[i].e_x, tv[i].e_y});
      chk($sformatf("tv%0d_act", i), 32'(frame_active), 32'(tv[i].e_act));
      chk($sformatf("tv%0d_done", i), 32'(frame_done), 32'(tv[i].e_done));
      chk($sformatf("tv%0d_lvl", i), 32'(fifo_level), 32'(tv[i].e_lvl));
    end

    // Broken zero run does not sync
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 8'h00, 0);
    cyc(0, 1, 8'h05, 0);
    chk("brk_hunt", 32'(frame_active), 0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 8'h00, 0);
    chk("brk_7zero", 32'(frame_active), 0);
    cyc(0, 1, 8'h00, 0);
    chk("brk_8zero", 32'(frame_active), 1);

    // Overflow: DEPTH+3 points with no consumer
    cyc(1, 0, 0, 0);
    send_sync(0);
    for (int i = 0; i < DEPTH + 3; i++) send_word(pt_word(i), 0);
    chk("ovf_level", 32'(fifo_level), DEPTH);
    chk("ovf_flag", 32'(overflow), 1);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("ovf_rd%0d", i), {7'd0, pt_draw, pt_x, pt_y}, {7'd0, pt_word(i)[24:0]});
      cyc(0, 0, 0, 1);
    end
    chk("ovf_empty", 32'(pt_valid), 0);

    // MAX_PTS abort, trailing points ignored
    cyc(1, 0, 0, 0);
    send_sync(1);
    hs_cnt = 0;
    for (int i = 0; i < MAX_PTS; i++) send_word(pt_word(i), 1);
    chk("abort_pulse", 32'(frame_abort), 1);
    chk("abort_act", 32'(frame_active), 0);
    send_word(pt_word(100), 1);
    send_word(pt_word(101), 1);
    chk("abort_pulse_gone", 32'(frame_abort), 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("abort_hs", hs_cnt, MAX_PTS);
    chk("abort_empty", 32'(fifo_level), 0);

    // Push into full FIFO with simultaneous pop
    cyc(1, 0, 0, 0);
    send_sync(0);
    for (int i = 0; i < DEPTH; i++) send_word(pt_word(i), 0);
    chk("full_level", 32'(fifo_level), DEPTH);
    for (int i = 3; i >= 1; i--) cyc(0, 1, pt_word(DEPTH)[8*i +: 8], 0);
    cyc(0, 1, pt_word(DEPTH)[7:0], 1);
    chk("fpp_level", 32'(fifo_level), DEPTH);
    chk("fpp_ovf", 32'(overflow), 0);
    for (int i = 1; i <= DEPTH; i++) begin
      chk($sformatf("fpp_rd%0d", i), {7'd0, pt_draw, pt_x, pt_y}, {7'd0, pt_word(i)[24:0]});
      cyc(0, 0, 0, 1);
    end

    // Reset mid-frame with buffered points
    cyc(1, 0, 0, 0);
    send_sync(0);
    for (int i = 0; i < 5; i++) send_word(pt_word(i), 0);
    cyc(0, 1, 8'h01, 0);
    cyc(0, 1, 8'hAB, 0);
    cyc(1, 1, 8'hCD, 1);
    chk("mrst_valid", 32'(pt_valid), 0);
    chk("mrst_level", 32'(fifo_level), 0);
    chk("mrst_act", 32'(frame_active), 0);
    send_sync(0);
    send_word(32'h01ABC123, 0);
    chk("mrst_pt", {7'd0, pt_valid, pt_draw, pt_x, pt_y}, {7'd0, 1'b1, 1'b1, 12'hABC, 12'h123});

    // Randomized frames against the model
    cyc(1, 0, 0, 0);
    for (int f = 0; f < 25; f++) begin
      int rp, ng, np;
      logic [31:0] w;
      rp = $urandom_range(0, 4);
      ng = $urandom_range(0, 10);
      for (int g = 0; g < ng; g++) begin
        if ($urandom % 4 == 0) cyc(0, 0, 0, ($urandom % 4) < rp);
        cyc(0, 1, 8'($urandom), ($urandom % 4) < rp);
      end
      for (int s = 0; s < SYNC_LEN; s++) begin
        if ($urandom % 4 == 0) cyc(0, 0, 0, ($urandom % 4) < rp);
        cyc(0, 1, 8'h00, ($urandom % 4) < rp);
      end
      np = $urandom_range(0, 80);
      for (int p = 0; p <= np; p++) begin
        w = (p == np) ? END_WORD : $urandom;
        for (int k = 3; k >= 0; k--) begin
          if ($urandom % 4 == 0) cyc(0, 0, 0, ($urandom % 4) < rp);
          cyc(0, 1, w[8*k +: 8], ($urandom % 4) < rp);
        end
      end
      if ($urandom % 6 == 0) cyc(1, 0, 0, 0);
    end
    for (int i = 0; i < DEPTH + 2; i++) cyc(0, 0, 0, 1);
    chk("final_empty", 32'(fifo_level), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
